scan_mux_ctrl: RTL and testbench
================================

Name: scan_mux_ctrl

Overview:
Parametrised, registered N-channel selector; generalises the team's fixed 4:1 combinational mux.
Routes one W-bit channel of a packed input bus to a registered output.
Channel choice is set by one of four modes: manual select, timed auto-scan, freeze, or masked auto-scan.
Sits between the pad-level input bus (ui_in/uio_in) and the output pins in the top wrapper.

Parameters:
N_CH, 4, number of input channels (2..16)
W, 1, bits per channel
DWELL_W, 8, width of dwell counter / dwell input
SEL_W, $clog2(N_CH), width of channel index (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  clock enable; 0 freezes all state
din  in  N_CH*W  packed channels; channel k = din[k*W +: W]
mode  in  2  00 manual, 01 auto-scan, 10 freeze, 11 masked scan
sel  in  SEL_W  manual channel index
dwell  in  DWELL_W  cycles per channel minus one (auto/masked modes)
mask  in  N_CH  channel enable mask for masked scan
dout  out  W  registered selected channel data
cur_ch  out  SEL_W  currently selected channel index (registered)
switched  out  1  one-cycle pulse when cur_ch changed on this edge

Behaviour:
- Reset (async assert, sync release):
  - dout=0, cur_ch=0, switched=0.
  - Internal dwell counter cnt=0, internal mode_q=00.
- en=0: cur_ch, cnt, dout and mode_q hold; switched=0.
- All remaining rules apply on rising clk with en=1.
- Data path: dout <= din[cur_ch] using the pre-edge cur_ch.
  - A channel switch therefore appears on dout one cycle after cur_ch updates (2-cycle latency from switch decision).
- Mode change: mode_q <= mode.
  - If mode != mode_q, cnt <= 0 this cycle.
  - The new mode's channel rule applies in the same cycle.
- Manual (00):
  - If sel < N_CH: cur_ch <= sel.
  - Else: cur_ch holds (out-of-range select ignored).
  - cnt held at 0.
- Auto-scan (01):
  - If cnt == dwell: cur_ch <= (cur_ch == N_CH-1) ? 0 : cur_ch+1, and cnt <= 0.
  - Else: cnt <= cnt+1.
  - dwell=0 advances every cycle; dwell=max gives 2^DWELL_W cycles per channel.
  - A dwell change mid-count takes effect at the next comparison; if cnt > new dwell, cnt continues counting and wraps at 2^DWELL_W before matching.
- Freeze (10): cur_ch holds, cnt <= 0, dout keeps sampling din[cur_ch].
- Masked scan (11):
  - Same cnt rule as auto-scan.
  - On advance, cur_ch <= first index j with mask[j]=1, searching cur_ch+1 upward with wrap to 0, ending at cur_ch.
  - Only the current bit set: cur_ch unchanged.
  - mask all zero: cur_ch holds.
  - A masked-off current channel is left at the next advance, not immediately.
- switched: 1 exactly when cur_ch's new value differs from its old value; 0 otherwise, including same-value reloads.
- Reset asserted mid-scan: immediate return to reset values; scanning restarts at channel 0 in manual mode_q.

Decomposition:
- Shared package scan_mux_pkg:
  - Mode constants MODE_MANUAL=2'b00, MODE_AUTO=2'b01, MODE_FREEZE=2'b10, MODE_MASKED=2'b11.
  - Function for SEL_W derivation.
- One combinational sub-module scan_next_ch (N_CH, SEL_W): inputs cur_ch and mask (all-ones for auto mode); outputs next index and a found flag. Handles the wrap-around priority search.
- Counter, mode register and output register stay in scan_mux_ctrl.

Test Plan:
- Reset: hold rst_n=0 with din=4'b1111 and mode=01 -> dout=0, cur_ch=0, switched=0. Deassert; 3 cycles of manual sel=0 -> dout=din[0].
- Manual, N_CH=4 W=1, din=4'b1010: sel=1 -> cur_ch=1 next edge with switched=1, dout=1 one edge later. sel=1 again -> switched=0.
- Auto-scan dwell=2 -> cur_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 with switched pulses at each change. dwell=0 -> cur_ch changes every cycle.
- Masked scan mask=4'b1001, dwell=0, start cur_ch=0 -> 3,0,3,0. mask=0 -> cur_ch frozen, switched=0.
- en=0 for 5 cycles mid auto-scan with cnt=1 -> cur_ch, cnt and dout unchanged. After en=1, remaining dwell completes with no lost or extra count.
- Freeze from auto at cur_ch=2, then return to auto -> cur_ch stays 2 during freeze. After return, the first advance occurs dwell+1 cycles later (cnt cleared on mode change).

Source files
------------

// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scanning channel selector: mode encodings and
// the channel-index width helper.
package scan_mux_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;
  localparam logic [1:0] MODE_MASKED = 2'b11;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_w_f(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/scan_next_ch.sv
// Wrap-around priority search: finds the first enabled channel strictly after
// cur_ch_i (wrapping to 0), ending with cur_ch_i itself as the last candidate.
module scan_next_ch #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0] cur_ch_i,
  input  logic [N_CH-1:0]  mask_i,
  output logic [SEL_W-1:0] next_ch_o,
  output logic             found_o
);

  int idx_s;

  // Walk candidates from farthest to nearest so the nearest enabled one wins.
  always_comb begin
    next_ch_o = cur_ch_i;
    found_o   = 1'b0;
    idx_s     = 0;
    for (int k = N_CH; k >= 1; k--) begin
      idx_s     = (int'(cur_ch_i) + k) % N_CH;
      next_ch_o = mask_i[SEL_W'(idx_s)] ? SEL_W'(idx_s) : next_ch_o;
      found_o   = found_o | mask_i[SEL_W'(idx_s)];
    end
  end

endmodule

// File: rtl/scan_mux_ctrl.sv
// Registered N-channel selector with manual, timed auto-scan, freeze and
// masked auto-scan modes. Output data lags the channel index by one edge.
module scan_mux_ctrl
  import scan_mux_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int W       = 1,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = sel_w_f(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [N_CH*W-1:0]   din,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [N_CH-1:0]     mask,
  output logic [W-1:0]        dout,
  output logic [SEL_W-1:0]    cur_ch,
  output logic                switched
);

  logic [SEL_W-1:0]   cur_ch_q, cur_ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q;
  logic [W-1:0]       dout_q, dout_d;
  logic               switched_q, switched_d;

  logic [N_CH-1:0]    scan_mask_s;
  logic [SEL_W-1:0]   next_ch_s;
  logic               found_s;
  logic               sel_ok_s;
  logic               mode_chg_s;
  logic               cnt_hit_s;

  // Plain auto-scan searches with every channel enabled; masked scan uses mask.
  always_comb begin
    if (mode == MODE_MASKED) begin
      scan_mask_s = mask;
    end else begin
      scan_mask_s = {N_CH{1'b1}};
    end
  end

  scan_next_ch #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_next (
    .cur_ch_i  (cur_ch_q),
    .mask_i    (scan_mask_s),
    .next_ch_o (next_ch_s),
    .found_o   (found_s)
  );

  // Channel-selection and dwell-counter rules for the requested mode.
  always_comb begin
    sel_ok_s   = ({1'b0, sel} < (SEL_W+1)'(N_CH));
    mode_chg_s = (mode != mode_q);
    cnt_hit_s  = (cnt_q == dwell);
    cur_ch_d   = cur_ch_q;
    cnt_d      = {DWELL_W{1'b0}};
    case (mode)
      MODE_MANUAL: begin
        if (sel_ok_s) begin
          cur_ch_d = sel;
        end else begin
          cur_ch_d = cur_ch_q;
        end
      end
      MODE_AUTO, MODE_MASKED: begin
        if (cnt_hit_s) begin
          cnt_d = {DWELL_W{1'b0}};
          if (found_s) begin
            cur_ch_d = next_ch_s;
          end else begin
            cur_ch_d = cur_ch_q;
          end
        end else if (mode_chg_s) begin
          // Entering a scan mode restarts the dwell from zero.
          cnt_d = {DWELL_W{1'b0}};
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      MODE_FREEZE: begin
        cur_ch_d = cur_ch_q;
      end
      default: begin
        cur_ch_d = cur_ch_q;
      end
    endcase
    switched_d = (cur_ch_d != cur_ch_q);
    // Data follows the pre-edge channel, giving one extra edge of latency.
    dout_d     = din[int'(cur_ch_q)*W +: W];
  end

  // State and output registers; en=0 holds everything and drops the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_q   <= {SEL_W{1'b0}};
      cnt_q      <= {DWELL_W{1'b0}};
      mode_q     <= MODE_MANUAL;
      dout_q     <= {W{1'b0}};
      switched_q <= 1'b0;
    end else if (en) begin
      cur_ch_q   <= cur_ch_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode;
      dout_q     <= dout_d;
      switched_q <= switched_d;
    end else begin
      switched_q <= 1'b0;
    end
  end

  assign dout     = dout_q;
  assign cur_ch   = cur_ch_q;
  assign switched = switched_q;

endmodule

// File: tb/tb_scan_mux_ctrl.sv
// Directed self-checking bench for scan_mux_ctrl (N_CH=4, W=1, DWELL_W=8).
module tb_scan_mux_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] din;
  logic [1:0] mode;
  logic [1:0] sel;
  logic [7:0] dwell;
  logic [3:0] mask;
  logic [0:0] dout;
  logic [1:0] cur_ch;
  logic       switched;

  int pass_cnt  = 0;
  int total_cnt = 0;

  scan_mux_ctrl #(.N_CH(4), .W(1), .DWELL_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .mode     (mode),
    .sel      (sel),
    .dwell    (dwell),
    .mask     (mask),
    .dout     (dout),
    .cur_ch   (cur_ch),
    .switched (switched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; din = 4'b1111; mode = 2'b01;
    sel = 2'd0; dwell = 8'd0; mask = 4'b0000;
    tick(); tick();
    total_cnt++;
    if ({dout, cur_ch, switched} !== 4'b0000) $display("FAIL reset_vals got dout=%0d cur=%0d sw=%0d want 0/0/0", dout, cur_ch, switched);
    else pass_cnt++;
    rst_n = 1'b1; mode = 2'b00; sel = 2'd0;
    tick(); tick(); tick();
    total_cnt++;
    if (dout !== 1'b1 || cur_ch !== 2'd0) $display("FAIL reset_release got dout=%0d cur=%0d want 1/0", dout, cur_ch);
    else pass_cnt++;
  endtask

  task automatic test_manual();
    din = 4'b1010; sel = 2'd1;
    tick();
    total_cnt++;
    if (cur_ch !== 2'd1 || switched !== 1'b1 || dout !== 1'b0) $display("FAIL manual_sel1 got cur=%0d sw=%0d dout=%0d want 1/1/0", cur_ch, switched, dout);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cur_ch !== 2'd1 || switched !== 1'b0 || dout !== 1'b1) $display("FAIL manual_reload got cur=%0d sw=%0d dout=%0d want 1/0/1", cur_ch, switched, dout);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4];
    seq[0] = 2'd3; seq[1] = 2'd0; seq[2] = 2'd2; seq[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      sel = seq[i];
      tick();
      total_cnt++;
      if (cur_ch !== seq[i] || switched !== 1'b1) $display("FAIL b2b_%0d got cur=%0d sw=%0d want %0d/1", i, cur_ch, switched, seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_auto();
    int exp_seq [13];
    int prev;
    logic exp_sw;
    exp_seq = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
    sel = 2'd0; tick(); tick();
    mode = 2'b01; dwell = 8'd2;
    prev = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      exp_sw = (exp_seq[i] != prev);
      total_cnt++;
      if (cur_ch !== 2'(exp_seq[i]) || switched !== exp_sw || dout !== din[prev])
        $display("FAIL auto_d2_%0d got cur=%0d sw=%0d dout=%0d want %0d/%0d/%0d", i, cur_ch, switched, dout, exp_seq[i], exp_sw, din[prev]);
      else pass_cnt++;
      prev = exp_seq[i];
    end
    dwell = 8'd0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total_cnt++;
      if (cur_ch !== 2'(i % 4) || switched !== 1'b1) $display("FAIL auto_d0_%0d got cur=%0d sw=%0d want %0d/1", i, cur_ch, switched, i % 4);
      else pass_cnt++;
    end
  endtask

  task automatic test_masked();
    int exp_seq [4];
    exp_seq = '{3,0,3,0};
    mode = 2'b11; mask = 4'b1001; dwell = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (cur_ch !== 2'(exp_seq[i]) || switched !== 1'b1) $display("FAIL masked_%0d got cur=%0d sw=%0d want %0d/1", i, cur_ch, switched, exp_seq[i]);
      else pass_cnt++;
    end
    mask = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (cur_ch !== 2'd0 || switched !== 1'b0) $display("FAIL mask_zero_%0d got cur=%0d sw=%0d want 0/0", i, cur_ch, switched);
      else pass_cnt++;
    end
    mask = 4'b0001;
    tick(); tick();
    total_cnt++;
    if (cur_ch !== 2'd0 || switched !== 1'b0) $display("FAIL mask_self got cur=%0d sw=%0d want 0/0", cur_ch, switched);
    else pass_cnt++;
  endtask

  task automatic test_enable();
    mode = 2'b00; sel = 2'd0; tick();
    mode = 2'b01; dwell = 8'd2;
    tick(); tick();              // mode-change edge (cnt=0), then cnt=1
    en = 1'b0; din = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (cur_ch !== 2'd0 || switched !== 1'b0 || dout !== 1'b0) $display("FAIL en_hold_%0d got cur=%0d sw=%0d dout=%0d want 0/0/0", i, cur_ch, switched, dout);
      else pass_cnt++;
    end
    en = 1'b1;
    tick();
    total_cnt++;
    if (cur_ch !== 2'd0 || dout !== 1'b1) $display("FAIL en_resume1 got cur=%0d dout=%0d want 0/1", cur_ch, dout);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cur_ch !== 2'd1 || switched !== 1'b1) $display("FAIL en_resume2 got cur=%0d sw=%0d want 1/1", cur_ch, switched);
    else pass_cnt++;
  endtask

  task automatic test_freeze();
    tick(); tick(); tick();
    total_cnt++;
    if (cur_ch !== 2'd2) $display("FAIL frz_pre got cur=%0d want 2", cur_ch);
    else pass_cnt++;
    mode = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (cur_ch !== 2'd2 || switched !== 1'b0 || dout !== 1'b1) $display("FAIL frz_hold_%0d got cur=%0d sw=%0d dout=%0d want 2/0/1", i, cur_ch, switched, dout);
      else pass_cnt++;
    end
    mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (cur_ch !== 2'd2) $display("FAIL frz_ret_%0d got cur=%0d want 2", i, cur_ch);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (cur_ch !== 2'd3 || switched !== 1'b1) $display("FAIL frz_adv got cur=%0d sw=%0d want 3/1", cur_ch, switched);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    tick();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({dout, cur_ch, switched} !== 4'b0000) $display("FAIL reset_mid got dout=%0d cur=%0d sw=%0d want 0/0/0", dout, cur_ch, switched);
    else pass_cnt++;
    tick();
    rst_n = 1'b1; mode = 2'b00; sel = 2'd2;
    tick();
    total_cnt++;
    if (cur_ch !== 2'd2 || switched !== 1'b1) $display("FAIL reset_mid_manual got cur=%0d sw=%0d want 2/1", cur_ch, switched);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_back_to_back();
    test_auto();
    test_masked();
    test_enable();
    test_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
